// File: rtl/kb_cmd_decoder.sv
// ---------------------------------------------------------------------------
// kb_cmd_decoder
//
// Purpose:
//   Turns PS/2 set-2 scan codes into configuration commands for a small
//   front panel. Function keys select a mode, keypad '+' saves and leaves
//   configuration, and the arrow keys (extended codes) produce one-cycle
//   navigation strobes while a mode is selected. A four-state prefix FSM
//   (IDLE / EXT / BRK / EXT_BRK) tracks the E0 and F0 prefixes, so break
//   codes never trigger commands.
//
// Optional feature:
//   KB_TYPEMATIC_FILTER_EN - when defined, the last make code and its
//   extended flag are stored. A repeated identical make is then ignored
//   until the matching break code arrives. Without the macro every
//   typematic repeat acts, and the last-key register is not built.
//
// Parameters:
//   N          scan-code width (default 8)
//   NUM_MODES  number of selectable function-key modes, 1..4 (default 3)
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous active-high reset, highest priority
//   key_code       scan code, qualified by got_code_tick
//   got_code_tick  one-cycle strobe marking a new key_code
//   reset_guardar  synchronous clear of guardar / save_pulse
//   mode           one-hot selected mode (bit0=F1 .. bit3=F4)
//   configurando   high while any mode is selected
//   Fs             display code of the active mode (F1..F4, 00 when none)
//   guardar        level flag set by the save key
//   save_pulse     one-cycle strobe on each accepted save key
//   nav            one-cycle strobes {right,left,down,up}
//   key_err        one-cycle strobe on a prefix-protocol error
// ---------------------------------------------------------------------------
module kb_cmd_decoder #(
  parameter int N         = 8,
  parameter int NUM_MODES = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         key_code,
  input  logic                 got_code_tick,
  input  logic                 reset_guardar,
  output logic [NUM_MODES-1:0] mode,
  output logic                 configurando,
  output logic [N-1:0]         Fs,
  output logic                 guardar,
  output logic                 save_pulse,
  output logic [3:0]           nav,
  output logic                 key_err
);

  localparam logic [N-1:0] C_EXT   = N'(8'hE0);
  localparam logic [N-1:0] C_BRK   = N'(8'hF0);
  localparam logic [N-1:0] C_F1    = N'(8'h05);
  localparam logic [N-1:0] C_F2    = N'(8'h06);
  localparam logic [N-1:0] C_F3    = N'(8'h04);
  localparam logic [N-1:0] C_F4    = N'(8'h0C);
  localparam logic [N-1:0] C_SAVE  = N'(8'h79);
  localparam logic [N-1:0] C_UP    = N'(8'h75);
  localparam logic [N-1:0] C_DOWN  = N'(8'h72);
  localparam logic [N-1:0] C_LEFT  = N'(8'h6B);
  localparam logic [N-1:0] C_RIGHT = N'(8'h74);
  localparam logic [N-1:0] C_FS0   = N'(8'hF1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXT     = 2'd1,
    S_BRK     = 2'd2,
    S_EXT_BRK = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [NUM_MODES-1:0] mode_q, mode_d;
  logic [N-1:0]         fs_q, fs_d;
  logic                 guardar_q, guardar_d;
  logic                 save_q, save_d;
  logic [3:0]           nav_q, nav_d;
  logic                 err_q, err_d;

  // Code classification for the current tick.
  logic is_ext, is_brk, is_prefix;
  logic make_tick, ext_make_tick, brk_tick;
  logic repeat_hit;
  logic make_ok, ext_make_ok;

  assign is_ext    = (key_code == C_EXT);
  assign is_brk    = (key_code == C_BRK);
  assign is_prefix = is_ext | is_brk;

  assign make_tick     = got_code_tick && (state_q == S_IDLE) && !is_prefix;
  assign ext_make_tick = got_code_tick && (state_q == S_EXT)  && !is_prefix;
  assign brk_tick      = got_code_tick && !is_prefix &&
                         ((state_q == S_BRK) || (state_q == S_EXT_BRK));

`ifdef KB_TYPEMATIC_FILTER_EN
  // {valid, extended, code} of the last make seen; valid=0 means empty.
  logic [N+1:0] last_q, last_d;
  logic         make_ext_flag;
  logic         brk_ext_flag;

  assign make_ext_flag = (state_q == S_EXT);
  assign brk_ext_flag  = (state_q == S_EXT_BRK);
  assign repeat_hit    = last_q == {1'b1, make_ext_flag, key_code};

  always_comb begin
    last_d = last_q;
    if (make_tick || ext_make_tick) begin
      last_d = {1'b1, make_ext_flag, key_code};
    end else if (brk_tick && (last_q == {1'b1, brk_ext_flag, key_code})) begin
      last_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= '0;
    end else begin
      last_q <= last_d;
    end
  end
`else
  assign repeat_hit = 1'b0;
`endif

  assign make_ok     = make_tick && !repeat_hit;
  assign ext_make_ok = ext_make_tick && !repeat_hit;

  // State register (FSM plus registered outputs).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      mode_q    <= '0;
      fs_q      <= '0;
      guardar_q <= 1'b0;
      save_q    <= 1'b0;
      nav_q     <= 4'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      fs_q      <= fs_d;
      guardar_q <= guardar_d;
      save_q    <= save_d;
      nav_q     <= nav_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (got_code_tick) begin
      unique case (state_q)
        S_IDLE: begin
          if (is_ext)      state_d = S_EXT;
          else if (is_brk) state_d = S_BRK;
        end
        S_EXT: begin
          if (is_brk)      state_d = S_EXT_BRK;
          else if (!is_ext) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output logic: computes the next value of every registered output.
  logic       sel_hit;
  logic [1:0] sel_idx;

  always_comb begin
    sel_hit = 1'b0;
    sel_idx = 2'd0;
    if (key_code == C_F1) begin
      sel_hit = 1'b1; sel_idx = 2'd0;
    end else if (key_code == C_F2) begin
      sel_hit = 1'b1; sel_idx = 2'd1;
    end else if (key_code == C_F3) begin
      sel_hit = 1'b1; sel_idx = 2'd2;
    end else if (key_code == C_F4) begin
      sel_hit = 1'b1; sel_idx = 2'd3;
    end
    // Modes beyond NUM_MODES do not exist in this build.
    if (int'(sel_idx) >= NUM_MODES) sel_hit = 1'b0;
  end

  always_comb begin
    mode_d    = mode_q;
    fs_d      = fs_q;
    guardar_d = guardar_q;
    save_d    = 1'b0;
    nav_d     = 4'b0;
    err_d     = 1'b0;

    // A prefix is only legal as E0 in IDLE, F0 in IDLE or F0 after E0.
    if (got_code_tick && is_prefix && (state_q != S_IDLE) &&
        !((state_q == S_EXT) && is_brk)) begin
      err_d = 1'b1;
    end

    if (make_ok) begin
      if (sel_hit) begin
        for (int i = 0; i < NUM_MODES; i++) begin
          mode_d[i] = (i == int'(sel_idx));
        end
        fs_d      = C_FS0 + N'(sel_idx);
        guardar_d = 1'b0;
      end else if (key_code == C_SAVE) begin
        mode_d    = '0;
        fs_d      = '0;
        guardar_d = 1'b1;
        save_d    = 1'b1;
      end
    end

    if (ext_make_ok && (|mode_q)) begin
      if (key_code == C_UP)         nav_d = 4'b0001;
      else if (key_code == C_DOWN)  nav_d = 4'b0010;
      else if (key_code == C_LEFT)  nav_d = 4'b0100;
      else if (key_code == C_RIGHT) nav_d = 4'b1000;
    end

    // Clearing the save flag wins over a save key in the same cycle.
    if (reset_guardar) begin
      guardar_d = 1'b0;
      save_d    = 1'b0;
    end
  end

  assign mode         = mode_q;
  assign configurando = |mode_q;
  assign Fs           = fs_q;
  assign guardar      = guardar_q;
  assign save_pulse   = save_q;
  assign nav          = nav_q;
  assign key_err      = err_q;

endmodule

// File: tb/tb_kb_cmd_decoder.sv
// Scoreboard bench: two decoders (NUM_MODES=3 and NUM_MODES=4) share the
// same stimulus; each event pushes hand-written expected outputs for both,
// and the monitor pops and compares on the cycle after the event.
module tb_kb_cmd_decoder;

`ifdef KB_TYPEMATIC_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] mode;
    logic       conf;
    logic [7:0] fs;
    logic       g;
    logic       s;
    logic [3:0] nav;
    logic       err;
  } out_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] key_code = 8'h00;
  logic       got_code_tick = 1'b0;
  logic       reset_guardar = 1'b0;

  logic [2:0] mode3;  logic conf3; logic [7:0] fs3; logic g3; logic s3; logic [3:0] nav3; logic err3;
  logic [3:0] mode4;  logic conf4; logic [7:0] fs4; logic g4; logic s4; logic [3:0] nav4; logic err4;

  kb_cmd_decoder #(.N(8), .NUM_MODES(3)) dut3 (
    .clk(clk), .reset(reset), .key_code(key_code), .got_code_tick(got_code_tick),
    .reset_guardar(reset_guardar), .mode(mode3), .configurando(conf3), .Fs(fs3),
    .guardar(g3), .save_pulse(s3), .nav(nav3), .key_err(err3));

  kb_cmd_decoder #(.N(8), .NUM_MODES(4)) dut4 (
    .clk(clk), .reset(reset), .key_code(key_code), .got_code_tick(got_code_tick),
    .reset_guardar(reset_guardar), .mode(mode4), .configurando(conf4), .Fs(fs4),
    .guardar(g4), .save_pulse(s4), .nav(nav4), .key_err(err4));

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  out_t  q3[$];
  out_t  q4[$];
  string qn[$];

  logic evt_q = 1'b0;
  logic armed = 1'b0;

  always @(posedge clk) evt_q <= got_code_tick | reset | reset_guardar;

  out_t act3, act4;
  always_comb begin
    act3 = '{mode: {1'b0, mode3}, conf: conf3, fs: fs3, g: g3, s: s3, nav: nav3, err: err3};
    act4 = '{mode: mode4, conf: conf4, fs: fs4, g: g4, s: s4, nav: nav4, err: err4};
  end

  // Expected outputs for a given mode and flags; configurando and Fs follow
  // directly from the selected mode.
  function automatic out_t mk(input logic [3:0] m, input logic g, input logic s,
                              input logic [3:0] nv, input logic e);
    out_t o;
    o.mode = m;
    o.conf = |m;
    o.fs   = (m == 4'b0001) ? 8'hF1 : (m == 4'b0010) ? 8'hF2 :
             (m == 4'b0100) ? 8'hF3 : (m == 4'b1000) ? 8'hF4 : 8'h00;
    o.g    = g;
    o.s    = s;
    o.nav  = nv;
    o.err  = e;
    return o;
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (evt_q) begin
      if (q3.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_event: actual=event required=none");
      end else begin
        out_t e3, e4;
        string nm;
        e3 = q3.pop_front(); e4 = q4.pop_front(); nm = qn.pop_front();
        armed <= 1'b1;
        total++;
        if (act3 !== e3) begin
          bad++;
          $display("FAIL %s n3: actual=%h required=%h", nm, act3, e3);
        end
        total++;
        if (act4 !== e4) begin
          bad++;
          $display("FAIL %s n4: actual=%h required=%h", nm, act4, e4);
        end
        $display("txn %s: n3=%h n4=%h", nm, act3, act4);
      end
    end else if (armed) begin
      total++;
      if ({s3, nav3, err3, s4, nav4, err4} !== 12'h000) begin
        bad++;
        $display("FAIL idle_strobes: actual=%h required=000", {s3, nav3, err3, s4, nav4, err4});
      end
    end
  end

  task automatic ev(input logic tk, input logic [7:0] c, input logic rg, input logic rst,
                    input string nm, input out_t e3, input out_t e4);
    @(posedge clk); #1;
    got_code_tick = tk; key_code = c; reset_guardar = rg; reset = rst;
    q3.push_back(e3); q4.push_back(e4); qn.push_back(nm);
    @(posedge clk); #1;
    got_code_tick = 1'b0; key_code = 8'h00; reset_guardar = 1'b0; reset = 1'b0;
  endtask

  task automatic same(input logic [7:0] c, input logic rg, input string nm, input out_t e);
    ev(1'b1, c, rg, 1'b0, nm, e, e);
  endtask

  initial begin
    out_t Z, M1, M2, M8;
    Z  = mk(4'b0000, 0, 0, 4'b0, 0);
    M1 = mk(4'b0001, 0, 0, 4'b0, 0);
    M2 = mk(4'b0010, 0, 0, 4'b0, 0);
    M8 = mk(4'b1000, 0, 0, 4'b0, 0);

    repeat (2) @(posedge clk);
    ev(0, 8'h00, 0, 1, "reset", Z, Z);

    same(8'h06, 0, "sel_f2", M2);
    same(8'hF0, 0, "brk_pfx", M2);
    same(8'h06, 0, "brk_06", M2);
    same(8'hF0, 0, "brk_pfx2", M2);
    same(8'h05, 0, "brk_05", M2);
    same(8'hF0, 0, "brk_pfx3", M2);
    same(8'hF0, 0, "brk_err", mk(4'b0010, 0, 0, 4'b0, 1));
    same(8'h05, 0, "sel_f1", M1);

    same(8'hE0, 0, "ext_pfx", M1);
    same(8'h75, 0, "nav_up", mk(4'b0001, 0, 0, 4'b0001, 0));
    same(8'hE0, 0, "ext_pfx", M1);
    same(8'h72, 0, "nav_down", mk(4'b0001, 0, 0, 4'b0010, 0));
    same(8'hE0, 0, "ext_pfx", M1);
    same(8'h6B, 0, "nav_left", mk(4'b0001, 0, 0, 4'b0100, 0));
    same(8'hE0, 0, "ext_pfx", M1);
    same(8'h74, 0, "nav_right", mk(4'b0001, 0, 0, 4'b1000, 0));

    same(8'hE0, 0, "ext_pfx", M1);
    same(8'hE0, 0, "ext_err", mk(4'b0001, 0, 0, 4'b0, 1));
    same(8'h75, 0, "nav_after_err", mk(4'b0001, 0, 0, 4'b0001, 0));

    same(8'hE0, 0, "ext_pfx", M1);
    same(8'hF0, 0, "ext_brk_pfx", M1);
    same(8'h75, 0, "ext_brk", M1);

    same(8'h79, 0, "save", mk(4'b0000, 1, 1, 4'b0, 0));
    same(8'hE0, 0, "ext_pfx", mk(4'b0000, 1, 0, 4'b0, 0));
    same(8'h72, 0, "nav_unconf", mk(4'b0000, 1, 0, 4'b0, 0));
    same(8'h05, 0, "sel_clr_g", M1);
    same(8'h79, 1, "save_rg", Z);
    same(8'hF0, 0, "brk_pfx", Z);
    same(8'h79, 0, "brk_79", Z);

    same(8'h79, 0, "rep1", mk(4'b0000, 1, 1, 4'b0, 0));
    same(8'h79, 0, "rep2", mk(4'b0000, 1, !FILT, 4'b0, 0));
    same(8'hF0, 0, "rep_brk_pfx", mk(4'b0000, 1, 0, 4'b0, 0));
    same(8'h79, 0, "rep_brk", mk(4'b0000, 1, 0, 4'b0, 0));
    same(8'h79, 0, "rep3", mk(4'b0000, 1, 1, 4'b0, 0));

    ev(0, 8'h00, 1, 0, "rg_only", Z, Z);

    ev(1, 8'h0C, 0, 0, "sel_f4", Z, M8);
    ev(1, 8'h12, 0, 0, "unlisted", Z, M8);
    ev(1, 8'hE0, 0, 0, "ext_pfx", Z, M8);
    ev(1, 8'h75, 0, 0, "nav_f4", Z, mk(4'b1000, 0, 0, 4'b0001, 0));

    ev(1, 8'hE0, 0, 0, "ext_pfx", Z, M8);
    ev(0, 8'h00, 0, 1, "reset_mid", Z, Z);
    same(8'h05, 0, "post_rst", M1);

    ev(1, 8'h06, 1, 1, "rst_tick", Z, Z);
    same(8'h05, 0, "sel_f1b", M1);

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    total++;
    if (q3.size() != 0) begin
      bad++;
      $display("FAIL queue_drain: actual=%0d required=0", q3.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
